// File: rtl/gain_pkg.sv
// Shared types and constants for the double-buffered requantizer gain table.
package gain_pkg;

  localparam int NCHAN  = 2048;
  localparam int CHAN_W = 11;
  localparam int GAIN_W = 5;

  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NCHAN - 1);

  typedef logic [GAIN_W-1:0] gain_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/gain_bank.sv
// One NCHAN x GAIN_W gain bank: synchronous write, asynchronous read (LUT RAM).
// With GAIN_LOADER_READBACK_EN a second asynchronous read port is added for host readback.
module gain_bank
  import gain_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [CHAN_W-1:0] waddr,
  input  gain_t             wdata,
  input  logic [CHAN_W-1:0] raddr,
  output gain_t             rdata
`ifdef GAIN_LOADER_READBACK_EN
  ,
  input  logic [CHAN_W-1:0] raddr_b,
  output gain_t             rdata_b
`endif
);

  gain_t mem_r [NCHAN];

  // host write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

`ifdef GAIN_LOADER_READBACK_EN
  assign rdata_b = mem_r[raddr_b];
`endif

endmodule

// File: rtl/gain_loader.sv
// Host-side writer for the requantizer gain table: shadow bank written by the host,
// swapped into the active position at the next spectrum boundary after a commit.
// Optional host readback port enabled by defining GAIN_LOADER_READBACK_EN.
module gain_loader
  import gain_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              sync_in,
  input  logic [CHAN_W-1:0] addr,
  output logic [GAIN_W-1:0] gain,
  input  logic [CHAN_W-1:0] wr_addr,
  input  logic [GAIN_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              commit,
  output logic              swap_pending,
  output logic              bank_sel,
  output logic [15:0]       swap_count,
  output logic              wr_drop
`ifdef GAIN_LOADER_READBACK_EN
  ,
  input  logic [CHAN_W-1:0] rd_addr,
  input  logic              rd_bank,
  output logic [GAIN_W-1:0] rd_data
`endif
);

  state_t      state_r;
  logic        bank_sel_r;
  logic [15:0] swap_count_r;
  logic        wr_drop_r;
  logic        swap_event_s;
  logic        wr_ok_s;
  gain_t       rdata0_s;
  gain_t       rdata1_s;

  // Swapping on the last-channel edge makes channel 0 of the next spectrum read the new bank.
  assign swap_event_s = ce & (sync_in | (addr == LAST_CHAN));
  assign wr_ok_s      = wr_en & (state_r == IDLE);

`ifdef GAIN_LOADER_READBACK_EN
  gain_t       rb0_s;
  gain_t       rb1_s;
  logic [GAIN_W-1:0] rd_data_r;
`endif

  gain_bank u_bank0 (
    .clk     (clk),
    .we      (wr_ok_s & bank_sel_r),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (addr),
    .rdata   (rdata0_s)
`ifdef GAIN_LOADER_READBACK_EN
    ,
    .raddr_b (rd_addr),
    .rdata_b (rb0_s)
`endif
  );

  gain_bank u_bank1 (
    .clk     (clk),
    .we      (wr_ok_s & ~bank_sel_r),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (addr),
    .rdata   (rdata1_s)
`ifdef GAIN_LOADER_READBACK_EN
    ,
    .raddr_b (rd_addr),
    .rdata_b (rb1_s)
`endif
  );

  // commit/swap state machine; a commit while pending is simply ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      bank_sel_r   <= 1'b0;
      swap_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (commit) begin
            state_r <= PENDING;
          end
        end
        PENDING: begin
          if (swap_event_s) begin
            state_r      <= IDLE;
            bank_sel_r   <= ~bank_sel_r;
            swap_count_r <= swap_count_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // sticky flag for host writes discarded during a pending swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_drop_r <= 1'b0;
    end else if (wr_en && (state_r == PENDING)) begin
      wr_drop_r <= 1'b1;
    end
  end

`ifdef GAIN_LOADER_READBACK_EN
  // registered host readback of either bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r <= 5'd0;
    end else begin
      rd_data_r <= rd_bank ? rb1_s : rb0_s;
    end
  end

  assign rd_data = rd_data_r;
`endif

  assign gain         = bank_sel_r ? rdata1_s : rdata0_s;
  assign swap_pending = (state_r == PENDING);
  assign bank_sel     = bank_sel_r;
  assign swap_count   = swap_count_r;
  assign wr_drop      = wr_drop_r;

endmodule

// File: tb/tb_gain_loader.sv
// Self-checking bench for gain_loader: directed scenarios plus randomized traffic
// compared cycle by cycle against a table-level reference model.
module tb_gain_loader;
  import gain_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        sync_in = 1'b0;
  logic [10:0] addr = 11'd0;
  logic [10:0] wr_addr = 11'd0;
  logic [4:0]  wr_data = 5'd0;
  logic        wr_en = 1'b0;
  logic        commit = 1'b0;
  logic [4:0]  gain;
  logic        swap_pending;
  logic        bank_sel;
  logic [15:0] swap_count;
  logic        wr_drop;
  logic [10:0] rd_addr = 11'd0;
  logic        rd_bank = 1'b0;
`ifdef GAIN_LOADER_READBACK_EN
  logic [4:0]  rd_data;
`endif

  gain_loader dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .sync_in      (sync_in),
    .addr         (addr),
    .gain         (gain),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .commit       (commit),
    .swap_pending (swap_pending),
    .bank_sel     (bank_sel),
    .swap_count   (swap_count),
    .wr_drop      (wr_drop)
`ifdef GAIN_LOADER_READBACK_EN
    ,
    .rd_addr      (rd_addr),
    .rd_bank      (rd_bank),
    .rd_data      (rd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: two gain tables, which one is live, and the host-visible status
  logic [4:0] m_mem   [2][NCHAN];
  bit         m_known [2][NCHAN];
  int         m_sel  = 0;
  bit         m_pend = 1'b0;
  bit         m_drop = 1'b0;
  int         m_cnt  = 0;
  bit         rb_random = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_sel"},  32'(bank_sel),     32'(m_sel));
    check({tag, "_pend"}, 32'(swap_pending), 32'(m_pend));
    check({tag, "_cnt"},  32'(swap_count),   32'(m_cnt % 65536));
    check({tag, "_drop"}, 32'(wr_drop),      32'(m_drop));
  endtask

  // one clock cycle: called and returns at a negedge
  task automatic step(input bit c, input bit s, input int a, input bit we,
                      input int wa, input logic [4:0] wd, input bit cm);
    logic [4:0] exp_rd;
    bit         rd_known;
    bit         ev;
    ce = c; sync_in = s; addr = 11'(a);
    wr_en = we; wr_addr = 11'(wa); wr_data = wd; commit = cm;
    if (rb_random) begin
      rd_addr = 11'($urandom_range(0, NCHAN - 1));
      rd_bank = 1'($urandom_range(0, 1));
    end
    #1;
    if (m_known[m_sel][a]) check("gain", 32'(gain), 32'(m_mem[m_sel][a]));
    exp_rd   = m_mem[rd_bank][rd_addr];
    rd_known = m_known[rd_bank][rd_addr];
    @(posedge clk);
    if (we) begin
      if (m_pend) m_drop = 1'b1;
      else begin
        m_mem[1 - m_sel][wa]   = wd;
        m_known[1 - m_sel][wa] = 1'b1;
      end
    end
    ev = c && (s || a == NCHAN - 1);
    if (m_pend) begin
      if (ev) begin
        m_sel  = 1 - m_sel;
        m_cnt  = m_cnt + 1;
        m_pend = 1'b0;
      end
    end else if (cm) begin
      m_pend = 1'b1;
    end
    #1;
    check_status("st");
`ifdef GAIN_LOADER_READBACK_EN
    if (rd_known) check("rd_data", 32'(rd_data), 32'(exp_rd));
`else
    if (rd_known && exp_rd === 5'bx) check("rd_model", 32'd0, 32'd1);
`endif
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b0);
  endtask

  task automatic model_reset();
    m_sel = 0; m_pend = 1'b0; m_drop = 1'b0; m_cnt = 0;
  endtask

  int         cnt0;
  int         sel0;
  logic [4:0] rnd;

  initial begin
    // reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_status("reset");
`ifdef GAIN_LOADER_READBACK_EN
    check("reset_rd", 32'(rd_data), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // first load: B1[5]=0x1A, commit, sync pulse
    step(1'b0, 1'b0, 0, 1'b1, 5, 5'h1A, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b1);
    check("tp1_pend", 32'(swap_pending), 32'd1);
    step(1'b1, 1'b1, 5, 1'b0, 0, 5'd0, 1'b0);
    check("tp1_sel", 32'(bank_sel), 32'd1);
    check("tp1_cnt", 32'(swap_count), 32'd1);
    addr = 11'd5;
    #1;
    check("tp1_gain", 32'(gain), 32'h1A);
    @(negedge clk);

    // fill both banks completely so every read is predictable
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NCHAN; i++) begin
        rnd = 5'($urandom);
        step(1'b0, 1'b0, $urandom_range(0, NCHAN - 1), 1'b1, i, rnd, 1'b0);
      end
      step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b1);
      step(1'b1, 1'b1, 0, 1'b0, 0, 5'd0, 1'b0);
    end

    // mid-spectrum commit at channel 100; swap lands after channel 2047
    sel0 = m_sel;
    for (int a = 0; a < NCHAN; a++) begin
      rnd = 5'($urandom);
      step(1'b1, 1'b0, a, a < 100, $urandom_range(0, NCHAN - 1), rnd, a == 100);
      if (a == 2046) check("tp2_hold", 32'(bank_sel), 32'(sel0));
    end
    check("tp2_sel", 32'(bank_sel), 32'(1 - sel0));
    step(1'b1, 1'b0, 0, 1'b0, 0, 5'd0, 1'b0);

    // blocked write while pending, second commit ignored, ce=0 at 2047 holds the swap
    cnt0 = m_cnt;
    step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 0, 1'b1, 7, 5'h15, 1'b0);
    check("tp3_drop", 32'(wr_drop), 32'd1);
    step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b1);
    step(1'b0, 1'b0, NCHAN - 1, 1'b0, 0, 5'd0, 1'b0);
    check("tp5_hold", 32'(swap_pending), 32'd1);
    step(1'b1, 1'b0, NCHAN - 1, 1'b0, 0, 5'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, $urandom_range(0, NCHAN - 2), 1'b0, 0, 5'd0, 1'b0);
    check("tp4_cnt", 32'(swap_count), 32'((cnt0 + 1) % 65536));
    check("tp3_drop_sticky", 32'(wr_drop), 32'd1);

    // async reset while pending with B1 live, then readback of B1[5]
    if (m_sel == 0) begin
      step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b1);
      step(1'b1, 1'b1, 0, 1'b0, 0, 5'd0, 1'b0);
    end
    step(1'b0, 1'b0, 0, 1'b0, 0, 5'd0, 1'b1);
    check("tp6_pre_sel", 32'(bank_sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_status("async_rst");
`ifdef GAIN_LOADER_READBACK_EN
    check("async_rst_rd", 32'(rd_data), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    rb_random = 1'b0;
    rd_bank = 1'b1;
    rd_addr = 11'd5;
    idle(2);
    rb_random = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rnd = 5'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
           ($urandom_range(0, 7) == 0) ? NCHAN - 1 : $urandom_range(0, NCHAN - 1),
           $urandom_range(0, 1) == 1, $urandom_range(0, NCHAN - 1), rnd,
           $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gain_loader.md
# gain_loader

Host-side writer for the per-channel requantization gain table. Holds two 2048×5-bit banks: an active bank read combinationally by the requantizer, and a shadow bank written by the host. A host commit swaps the banks at the next spectrum boundary, so the requantizer never sees a partially updated table. Sits between the host register/bus bridge and the requantizer's `addr`/`gain` pair.

## Interface
- `NCHAN`, 2048: channels per spectrum (power of two).
- `GAIN_W`, 5: gain word width.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: clock enable shared with the requantizer.
- `sync_in` in 1: spectrum sync, same signal the requantizer sees.
- `addr` in 11: channel index from the requantizer.
- `gain` out 5: active-bank gain at `addr`.
- `wr_addr` in 11: host write channel.
- `wr_data` in 5: host write gain.
- `wr_en` in 1: host write strobe, one write per cycle.
- `commit` in 1: single-cycle request to swap banks.
- `swap_pending` out 1: commit accepted, swap not yet done.
- `bank_sel` out 1: index of the active bank.
- `swap_count` out 16: completed swaps, wraps at 0xFFFF→0.
- `wr_drop` out 1: sticky; a write was discarded.

## Operation
- Two banks, B0/B1. Active = `bank_sel`; shadow = `~bank_sel`.
- Read: `gain` = active[`addr`], combinational (LUT RAM). The requantizer samples it in the same cycle it drives `addr`.
- Write: `wr_en` & `~swap_pending` writes `wr_data` to shadow[`wr_addr`] on the clock edge. `ce` has no effect on writes.
- Writes are blocked while a swap is pending. `wr_en` & `swap_pending` discards the write and sets `wr_drop`. Only `rst` clears `wr_drop`.
- States:
  - IDLE: `commit` → PENDING.
  - PENDING: on swap event → IDLE, toggle `bank_sel`, increment `swap_count`.
- Swap event is either of:
  - `ce` & `addr`==NCHAN-1, so the swap lands after the last channel and channel 0 of the next spectrum reads the new bank.
  - `ce` & `sync_in`, which covers the first load before the requantizer is running.
- `commit` while in PENDING is ignored, with no counting or flag.
- `commit` in the same cycle as a swap event while in IDLE only enters PENDING; the swap happens at the next event.
- `commit` and `wr_en` in the same cycle while in IDLE: the write is accepted, then PENDING is entered.
- The host must copy any unchanged gains into the shadow bank itself; there is no auto-copy.

## Timing
- Reset values: `bank_sel`=0, `swap_pending`=0, `swap_count`=0, `wr_drop`=0, state IDLE.
- RAM contents are not reset. `gain` is combinational from B0 after reset.
- `commit` at edge N → `swap_pending`=1 after edge N.
- Swap event at edge M → `bank_sel` toggled, `swap_pending`=0 and `swap_count`+1, all after edge M. Reads in cycle M+1 use the new bank.
- Write at edge N: readable through `gain` after edge N+1 swap at the earliest, never in the same bank it was written as shadow.
- `rst` mid-PENDING drops the pending swap. The bank selection reverts to B0, even if B1 held the live table.
- `ce`=0 suppresses swap events only.

## Configuration
- `GAIN_LOADER_READBACK_EN` defined: adds ports `rd_addr` in 11, `rd_bank` in 1 and `rd_data` out 5.
  - `rd_data` = bank[`rd_bank`][`rd_addr`], registered, 1-cycle latency.
  - `rd_data` resets to 0.
- Undefined: these ports are absent and no readback logic is built.

## Structure
- Shared package `gain_pkg`: `NCHAN`, `CHAN_W`=11, `GAIN_W`, a gain word typedef, and the state enum (IDLE, PENDING).
- One sub-module, `gain_bank`: a single NCHAN×GAIN_W bank with synchronous write and asynchronous read. Instantiate it twice.

## Test plan
- Reset, then write B1[5]=0x1A and commit, then pulse `sync_in` with `ce`=1 → `bank_sel`=1, `swap_count`=1, `gain` at `addr`=5 is 0x1A the next cycle.
- While running, commit mid-spectrum at `addr`=100 → `gain` stays on the old bank through `addr`=2047; `bank_sel` toggles after the 2047 edge; `addr`=0 reads the new bank.
- `wr_en` while `swap_pending`=1 → shadow unchanged, `wr_drop`=1 until `rst`.
- Second commit while PENDING, then one swap event → `swap_count` increments by exactly 1; no further swap occurs.
- `addr`=2047 with `ce`=0 while PENDING → no swap; the next `ce`=1 at 2047 swaps.
- Assert `rst` asynchronously while PENDING with `bank_sel`=1 → all outputs return to reset values immediately. With readback enabled, `rd_data` returns B1[5] one cycle after `rd_bank`=1, `rd_addr`=5.
